// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem_responder_pkg                                        |
// | Purpose  : Shared types and constants for the data-memory responder:     |
// |            FSM state encoding, operation codes and the data word width.  |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package data_mem_responder_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_sram_1p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_1p                                                       |
// | Purpose  : Single-port word array. Writes are synchronous; the read      |
// |            port is a combinational lookup so the owner can capture the   |
// |            addressed word on the same edge that it commits an operation. |
// | Ports    : clk  - clock                                                  |
// |            we   - write enable (write din to array[idx] on rising edge)  |
// |            idx  - word index                                             |
// |            din  - write data                                             |
// |            dout - contents of array[idx] (pre-write value)               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sram_1p #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout
);

  // Contents are intentionally not reset.
  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= din;
    end
  end

  assign dout = r_mem[idx];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem_responder                                            |
// | Purpose  : Memory-side end of the CPU data-memory interface. Accepts one |
// |            load/store request at a time, services it against a word      |
// |            array after a fixed LATENCY and stalls the pipeline meanwhile.|
// | Ports    : clk, rst       - clock, synchronous active-high reset         |
// |            MemRead        - load request                                 |
// |            MemWrite       - store request (wins if both are high)        |
// |            addr           - byte address, bit 0 ignored                  |
// |            w_data         - store data                                   |
// |            mems_data_out  - registered load data (0 after a store)       |
// |            mem_stall      - hold MEM stage / keep request stable         |
// |            mem_done       - one-cycle completion pulse                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] w_data,
  output logic [WORD_W-1:0] mems_data_out,
  output logic              mem_stall,
  output logic              mem_done
);

  // With LATENCY==1 the request cycle goes straight to DONE; otherwise the
  // counter covers the LATENCY-1 cycles spent in BUSY (it counts down to 0).
  localparam bit         SINGLE_CYCLE = (LATENCY == 1);
  localparam logic [3:0] CNT_LOAD     = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;
  logic                  r_op;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [WORD_W-1:0]     r_wdata;

  logic                  w_req;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_op_in;
  logic                  w_cur_op;
  logic [DEPTH_LOG2-1:0] w_cur_idx;
  logic [WORD_W-1:0]     w_cur_wdata;
  logic                  w_sram_we;
  logic [WORD_W-1:0]     w_sram_dout;
  logic                  w_unused_addr_bits;

  assign w_req   = MemRead | MemWrite;
  assign w_op_in = MemWrite ? OP_WRITE : OP_READ;

  // Bit 0 and everything above the array index are don't-care (word access,
  // address wrap).
  assign w_unused_addr_bits = ^addr;

  // In IDLE the operation comes straight from the ports (needed when a
  // single-cycle request commits on its own acceptance edge); afterwards the
  // held copy is used so request changes while BUSY have no effect.
  assign w_cur_op    = (r_state == ST_IDLE) ? w_op_in               : r_op;
  assign w_cur_idx   = (r_state == ST_IDLE) ? addr[DEPTH_LOG2:1]    : r_idx;
  assign w_cur_wdata = (r_state == ST_IDLE) ? w_data                : r_wdata;

  // A reset coinciding with the commit edge must drop the store.
  assign w_sram_we = w_commit & (w_cur_op == OP_WRITE) & ~rst;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    mem_stall    = 1'b0;
    mem_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          mem_stall = 1'b1;
          w_accept  = 1'b1;
          if (SINGLE_CYCLE) begin
            w_state_next = ST_DONE;
            w_commit     = 1'b1;
          end else begin
            w_state_next = ST_BUSY;
            w_cnt_next   = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        mem_stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_next = ST_DONE;
          w_commit     = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        mem_done     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 4'd0;
      mems_data_out <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_commit) begin
        mems_data_out <= (w_cur_op == OP_WRITE) ? '0 : w_sram_dout;
      end
    end
  end

  // Request capture; contents are only meaningful while an operation is open.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= w_op_in;
      r_idx   <= addr[DEPTH_LOG2:1];
      r_wdata <= w_data;
    end
  end

  sram_1p #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WORD_W)
  ) u_sram (
    .clk  (clk),
    .we   (w_sram_we),
    .idx  (w_cur_idx),
    .din  (w_cur_wdata),
    .dout (w_sram_dout)
  );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_mem_responder                                         |
// | Purpose  : Self-checking bench for data_mem_responder. Two instances     |
// |            (LATENCY 4 and 1) run directed and randomized traffic and are |
// |            compared every cycle against a transaction-level model.       |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_data_mem_responder;

  logic             clk = 1'b0;
  logic [1:0]       rst;
  logic [1:0]       mrd;
  logic [1:0]       mwr;
  logic [1:0][15:0] addr;
  logic [1:0][15:0] wd;
  logic [1:0][15:0] dout;
  logic [1:0]       stall;
  logic [1:0]       done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut0 (
    .clk(clk), .rst(rst[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]),
    .addr(addr[0]), .w_data(wd[0]), .mems_data_out(dout[0]),
    .mem_stall(stall[0]), .mem_done(done[0])
  );

  data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]),
    .addr(addr[1]), .w_data(wd[1]), .mems_data_out(dout[1]),
    .mem_stall(stall[1]), .mem_done(done[1])
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A request seen in idle at cycle t occupies the unit until cycle t+L,
  // where it completes with its effect already visible.
  bit          m_valid [2];
  bit          m_active[2];
  bit          m_wr    [2];
  bit          m_known_out[2];
  int          m_done_cyc[2];
  int          m_idx   [2];
  logic [15:0] m_wd    [2];
  logic [15:0] m_out   [2];
  logic [15:0] m_mem   [2][1024];
  bit          m_known [2][1024];

  task automatic model_reset(int k);
    m_valid[k]     = 1'b1;
    m_active[k]    = 1'b0;
    m_out[k]       = 16'h0;
    m_known_out[k] = 1'b1;
  endtask

  task automatic model_step(int k, int lat);
    logic req;
    logic es, ed;
    req = mrd[k] | mwr[k];
    if (!m_valid[k]) begin
      if (rst[k] === 1'b1) model_reset(k);
      return;
    end
    if (m_active[k] && cyc == m_done_cyc[k]) begin
      if (m_wr[k]) begin
        m_mem[k][m_idx[k]]   = m_wd[k];
        m_known[k][m_idx[k]] = 1'b1;
        m_out[k]             = 16'h0;
        m_known_out[k]       = 1'b1;
      end else begin
        m_out[k]       = m_mem[k][m_idx[k]];
        m_known_out[k] = m_known[k][m_idx[k]];
      end
    end
    es = m_active[k] ? (cyc < m_done_cyc[k]) : req;
    ed = m_active[k] && (cyc == m_done_cyc[k]);
    check($sformatf("stall[%0d] cyc=%0d", k, cyc), {31'b0, stall[k]}, {31'b0, es});
    check($sformatf("done[%0d] cyc=%0d", k, cyc), {31'b0, done[k]}, {31'b0, ed});
    if (m_known_out[k])
      check($sformatf("data[%0d] cyc=%0d", k, cyc), {16'b0, dout[k]}, {16'b0, m_out[k]});
    if (rst[k] === 1'b1) begin
      model_reset(k);
    end else if (m_active[k] && cyc == m_done_cyc[k]) begin
      m_active[k] = 1'b0;
    end else if (!m_active[k] && req) begin
      m_active[k]   = 1'b1;
      m_done_cyc[k] = cyc + lat;
      m_wr[k]       = mwr[k];
      m_idx[k]      = int'(addr[k] >> 1) % 1024;
      m_wd[k]       = wd[k];
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 4);
    model_step(1, 1);
  end

  // ---------------- stimulus ----------------
  task automatic drive(int k, bit r, bit w, logic [15:0] a, logic [15:0] d);
    @(posedge clk);
    #1;
    mrd[k]  = r;
    mwr[k]  = w;
    addr[k] = a;
    wd[k]   = d;
  endtask

  // Issue one request; returns cycles to mem_done, stall-high cycles seen
  // and the data output in the completion cycle.
  task automatic txn(int k, bit r, bit w, logic [15:0] a, logic [15:0] d,
                     bit hold, bit drop, output int lat, output int nstall,
                     output logic [15:0] q);
    drive(k, r, w, a, d);
    #1;
    lat    = 0;
    nstall = 0;
    while (done[k] !== 1'b1 && lat < 40) begin
      if (stall[k] === 1'b1) nstall++;
      @(posedge clk);
      #1;
      if (drop && lat == 0) begin
        mrd[k] = 1'b0;
        mwr[k] = 1'b0;
      end
      #1;
      lat++;
    end
    check($sformatf("txn_done_seen[%0d]", k), {31'b0, done[k]}, 32'd1);
    q = dout[k];
    if (!hold) drive(k, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset(int k, int n);
    @(posedge clk);
    #1;
    rst[k] = 1'b1;
    mrd[k] = 1'b0;
    mwr[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst[k] = 1'b0;
  endtask

  task automatic rand_run(int k);
    int          lat, ns, sel;
    logic [15:0] q, a;
    bit          r, w, hold, drop;
    for (int i = 0; i < 150; i++) begin
      sel       = $urandom_range(0, 9);
      w         = (sel < 4) || (sel == 9);
      r         = (sel >= 4);
      a         = 16'($urandom);
      a[10:1]   = 10'($urandom_range(0, 7));
      hold      = ($urandom_range(0, 3) == 0);
      drop      = !hold && ($urandom_range(0, 9) == 0);
      txn(k, r, w, a, 16'($urandom), hold, drop, lat, ns, q);
      if (!hold) repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 29) == 0) do_reset(k, 1);
    end
    drive(k, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, ns;
    logic [15:0] q;
    rst  = 2'b11;
    mrd  = 2'b00;
    mwr  = 2'b00;
    addr = '0;
    wd   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 2'b00;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_data[%0d]", k),  {16'b0, dout[k]},  32'h0);
      check($sformatf("reset_stall[%0d]", k), {31'b0, stall[k]}, 32'h0);
      check($sformatf("reset_done[%0d]", k),  {31'b0, done[k]},  32'h0);
    end

    // Prior value for the reset-abort test.
    txn(0, 1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0, 1'b0, lat, ns, q);

    txn(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, lat, ns, q);
    check("sw_latency", lat, 4);
    check("sw_stall_cycles", ns, 4);
    check("sw_data_zero", {16'b0, q}, 32'h0);
    txn(0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, lat, ns, q);
    check("lw_latency", lat, 4);
    check("lw_data_beef", {16'b0, q}, 32'hBEEF);

    // Both enables high -> store.
    txn(0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, lat, ns, q);
    check("both_data_zero", {16'b0, q}, 32'h0);
    txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, lat, ns, q);
    check("both_readback", {16'b0, q}, 32'h1234);

    // Back-to-back with request held through DONE.
    txn(0, 1'b0, 1'b1, 16'h0040, 16'hCAFE, 1'b1, 1'b0, lat, ns, q);
    check("b2b_sw_latency", lat, 4);
    txn(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, lat, ns, q);
    check("b2b_lw_latency", lat, 4);
    check("b2b_lw_data", {16'b0, q}, 32'hCAFE);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Address wrap: 0x0841 maps to the same word as 0x0040.
    txn(0, 1'b1, 1'b0, 16'h0841, 16'h0000, 1'b0, 1'b0, lat, ns, q);
    check("wrap_data", {16'b0, q}, 32'hCAFE);

    // Reset while BUSY drops the store.
    drive(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
    @(posedge clk);
    do_reset(0, 1);
    repeat (5) begin
      @(posedge clk);
      #2;
      check("abort_no_done", {31'b0, done[0]}, 32'h0);
    end
    txn(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, lat, ns, q);
    check("abort_old_value", {16'b0, q}, 32'h5555);

    // Single-cycle latency instance.
    txn(1, 1'b0, 1'b1, 16'h0010, 16'h1111, 1'b0, 1'b0, lat, ns, q);
    txn(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, lat, ns, q);
    check("l1_latency", lat, 1);
    check("l1_stall_cycles", ns, 1);
    check("l1_data", {16'b0, q}, 32'h1111);

    fork
      rand_run(0);
      rand_run(1);
    join

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
